mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: the execute stage presents an operation.
REQ-004 SHALL have port in_ready, output, 1 bit: the unit accepts an operation; high only in IDLE.
REQ-005 SHALL have port op, input, MDUOpType (3 bits): MUL, MULH, MULHU, DIV, DIVU, REM or REMU.
REQ-006 SHALL have port is_word, input, 1 bit: RV64 W variant (MULW, DIVW, DIVUW, REMW, REMUW).
REQ-007 SHALL have ports src1 and src2, input, u64 each: operands, already forwarded and muxed.
REQ-008 SHALL have port out_valid, output, 1 bit: result available.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream stage consumes the result.
REQ-010 SHALL have port result, output, u64: the final value.
REQ-011 SHALL have port flush, input, 1 bit: abandon any operation; no result is produced.

Function
REQ-012 SHALL implement three states: IDLE, BUSY and DONE.
REQ-013 IDLE: in_valid && in_ready SHALL latch op, is_word and the prepared operands, then move to BUSY.
REQ-014 Operand preparation SHALL be:
- W ops use src[31:0], sign-extended for signed ops and zero-extended for unsigned ops.
- Signed ops SHALL take magnitudes and record the result sign.
REQ-015 BUSY: multiply SHALL be shift-add, one bit per cycle; divide SHALL be restoring shift-subtract, one quotient bit per cycle.
REQ-016 The iteration count SHALL be 64, or 32 when is_word; a 7-bit counter tracks it, and the last iteration moves the state to DONE.
REQ-017 Latency SHALL be acceptance edge + N iteration cycles, then out_valid high from the next cycle (N = 64 or 32).
REQ-018 Division by zero SHALL skip BUSY and go directly to DONE (out_valid on the cycle after acceptance):
- quotient = all ones
- remainder = dividend
- W ops use the 32-bit values, sign-extended to 64 bits.
REQ-019 Signed overflow SHALL also go directly to DONE:
- Overflow cases: most-negative / -1, at 64 bits, or at 32 bits for W ops.
- quotient = dividend; remainder = 0.
REQ-020 Result selection SHALL be:
- MUL: low 64 bits of the product.
- MULH/MULHU: high 64 bits; MULH is signed-corrected by negating the 128-bit product.
- DIV/DIVU: quotient; REM/REMU: remainder.
- The remainder takes the sign of the dividend.
REQ-021 W ops SHALL return result[31:0] sign-extended to 64 bits, including DIVUW and REMUW.
REQ-022 DONE: out_valid SHALL be high and result stable until out_ready; out_valid && out_ready SHALL return the unit to IDLE.
REQ-023 in_ready SHALL be low in DONE: no same-cycle accept; a new accept occurs one cycle after the handshake at the earliest.
REQ-024 flush in any state SHALL force IDLE on the next edge:
- out_valid low on the next cycle.
- flush together with in_valid in IDLE SHALL NOT accept the operation.
- flush has priority over out_ready.
REQ-025 Operand inputs SHALL be ignored outside the accepting cycle; changes during BUSY SHALL NOT affect result.

Reset
REQ-026 Reset SHALL put the state in IDLE, set the counter to 0 and clear all datapath registers; in_ready SHALL be 1 on the first cycle after reset.
REQ-027 After reset, out_valid SHALL be 0 and result SHALL be 0.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL discard the operation without producing a result.

Structure
REQ-029 MDUOpType (enum, 3 bits) and the MDU_ITER_64 and MDU_ITER_32 constants SHALL live in the shared pipes package, beside the ALU source enums.
REQ-030 The iteration engine SHALL be one sub-module, mdu_iter_core: shift-add / shift-subtract step plus counter, with start, done and 128-bit acc.
REQ-031 mul_div_unit SHALL own the FSM, operand preparation, special cases and result fixup.

Verification
REQ-032 Directed scenarios a bench SHALL cover:
- MUL src1=7, src2=-3 -> result 0xFFFFFFFFFFFFFFEB; out_valid exactly 65 cycles after acceptance.
- DIV src1=-7, src2=2 -> 0xFFFFFFFFFFFFFFFD; REM on the same operands -> 0xFFFFFFFFFFFFFFFF.
- DIVU src2=0, src1=5 -> 0xFFFFFFFFFFFFFFFF; REMU on the same operands -> 5; out_valid 1 cycle after acceptance.
- DIVW src1=0x80000000, src2=0xFFFFFFFF -> 0xFFFFFFFF80000000; REMW on the same operands -> 0.
- MULHU src1=src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; hold out_ready=0 for 5 cycles -> result held stable, in_ready=0.
- flush at BUSY cycle 10 -> IDLE, no out_valid; the next MULW src1=src2=0x10000 -> 0, latency 33.

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared execute-pipe types: ALU source selects plus the multiply/divide unit's op encoding,
// iteration counts and FSM states.
package pipes_pkg;

    typedef enum logic [1:0] {
        SRC1_RS1,
        SRC1_PC,
        SRC1_ZERO
    } alu_src1_e;

    typedef enum logic [1:0] {
        SRC2_RS2,
        SRC2_IMM,
        SRC2_FOUR
    } alu_src2_e;

    typedef enum logic [2:0] {
        MDU_MUL   = 3'd0,
        MDU_MULH  = 3'd1,
        MDU_MULHU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_REM   = 3'd5,
        MDU_REMU  = 3'd6
    } MDUOpType;

    localparam logic [6:0] MDU_ITER_64 = 7'd64;
    localparam logic [6:0] MDU_ITER_32 = 7'd32;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_BUSY,
        MDU_DONE
    } mdu_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Bit-serial engine: shift-add multiply or restoring divide, one bit per cycle for 64 (or 32) cycles.
// done is high during the last iteration cycle; acc is final and stable on the following cycle.
module mdu_iter_core
    import pipes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         kill,
    input  logic         is_div,
    input  logic         is_word,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    output logic         done,
    output logic [127:0] acc
);

    logic [6:0]   cnt;
    logic [63:0]  mplier;
    logic [63:0]  divisor;
    logic         div_q;
    logic [63:0]  a_aligned;
    logic [64:0]  rem_shift;
    logic [63:0]  rem_new;
    logic         take;
    logic [127:0] acc_nxt;

    // Word ops park the 32 live bits at the top so both algorithms scan MSB-first.
    assign a_aligned = is_word ? {a[31:0], 32'd0} : a;
    assign done      = (cnt == 7'd1);

    always_comb begin
        rem_shift = acc[127:63];
        take      = (rem_shift >= {1'b0, divisor});
        rem_new   = take ? (rem_shift[63:0] - divisor) : rem_shift[63:0];
        if (div_q) begin
            acc_nxt = {rem_new, acc[62:0], take};
        end else begin
            acc_nxt = {acc[126:0], 1'b0} + (mplier[63] ? {64'd0, divisor} : 128'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 7'd0;
            acc     <= 128'd0;
            mplier  <= 64'd0;
            divisor <= 64'd0;
            div_q   <= 1'b0;
        end else if (kill) begin
            cnt <= 7'd0;
        end else if (start) begin
            cnt     <= is_word ? MDU_ITER_32 : MDU_ITER_64;
            divisor <= b;
            div_q   <= is_div;
            acc     <= is_div ? {64'd0, a_aligned} : 128'd0;
            mplier  <= is_div ? 64'd0 : a_aligned;
        end else if (cnt != 7'd0) begin
            cnt    <= cnt - 7'd1;
            acc    <= acc_nxt;
            mplier <= {mplier[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV64 M-extension unit: 65/33-cycle multiply/divide, 1-cycle divide-by-zero and overflow.
// Accepts only in IDLE; holds result with out_valid until out_ready; flush or reset abandons the op.
module mul_div_unit
    import pipes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  MDUOpType    op,
    input  logic        is_word,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    input  logic        flush
);

    mdu_state_e   state, state_nxt;
    MDUOpType     op_q;
    logic         word_q, neg_q, spec_vld;
    logic [63:0]  spec_q;

    logic         is_signed, is_div, quot_sel, neg_a, neg_b, res_neg;
    logic         div_zero, div_ovf, special, accept, core_start, core_done;
    logic [63:0]  opnd_a, opnd_b, mag_a, mag_b, most_neg, special_raw, special_val;
    logic [63:0]  raw, fix_val;
    logic [127:0] core_acc, prod_neg;

    always_comb begin
        is_signed = op inside {MDU_MULH, MDU_DIV, MDU_REM};
        is_div    = op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
        quot_sel  = op inside {MDU_DIV, MDU_DIVU};
        opnd_a    = is_word ? (is_signed ? sext32(src1[31:0]) : {32'd0, src1[31:0]}) : src1;
        opnd_b    = is_word ? (is_signed ? sext32(src2[31:0]) : {32'd0, src2[31:0]}) : src2;
        neg_a     = is_signed && opnd_a[63];
        neg_b     = is_signed && opnd_b[63];
        mag_a     = neg_a ? -opnd_a : opnd_a;
        mag_b     = neg_b ? -opnd_b : opnd_b;
        // Remainder follows the dividend; quotient and product follow the XOR of signs.
        res_neg   = (op == MDU_REM) ? neg_a : (neg_a ^ neg_b);
        most_neg  = is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero  = is_div && (opnd_b == 64'd0);
        div_ovf   = (op inside {MDU_DIV, MDU_REM}) && (opnd_a == most_neg) && (opnd_b == {64{1'b1}});
        special   = div_zero || div_ovf;
        if (div_zero) begin
            special_raw = quot_sel ? {64{1'b1}} : opnd_a;
        end else begin
            special_raw = quot_sel ? opnd_a : 64'd0;
        end
        special_val = is_word ? sext32(special_raw[31:0]) : special_raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MDU_IDLE: if (accept) state_nxt = special ? MDU_DONE : MDU_BUSY;
            MDU_BUSY: begin
                if (flush) state_nxt = MDU_IDLE;
                else if (core_done) state_nxt = MDU_DONE;
            end
            MDU_DONE: if (flush || out_ready) state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == MDU_IDLE);
        out_valid  = (state == MDU_DONE);
        accept     = in_valid && in_ready && !flush;
        core_start = accept && !special;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MDU_MUL;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            spec_vld <= 1'b0;
            spec_q   <= 64'd0;
        end else if (accept) begin
            op_q     <= op;
            word_q   <= is_word;
            neg_q    <= res_neg;
            spec_vld <= special;
            spec_q   <= special_val;
        end
    end

    mdu_iter_core u_core (
        .clk     (clk),
        .reset   (reset),
        .start   (core_start),
        .kill    (flush),
        .is_div  (is_div),
        .is_word (is_word),
        .a       (mag_a),
        .b       (mag_b),
        .done    (core_done),
        .acc     (core_acc)
    );

    // The engine goes idle after its last step, so acc (and hence result) is stable in DONE.
    always_comb begin
        prod_neg = -core_acc;
        case (op_q)
            MDU_MUL:   raw = core_acc[63:0];
            MDU_MULH:  raw = neg_q ? prod_neg[127:64] : core_acc[127:64];
            MDU_MULHU: raw = core_acc[127:64];
            MDU_DIV:   raw = neg_q ? -core_acc[63:0] : core_acc[63:0];
            MDU_DIVU:  raw = core_acc[63:0];
            MDU_REM:   raw = neg_q ? -core_acc[127:64] : core_acc[127:64];
            MDU_REMU:  raw = core_acc[127:64];
            default:   raw = 64'd0;
        endcase
        fix_val = word_q ? sext32(raw[31:0]) : raw;
        result  = spec_vld ? spec_q : fix_val;
    end

endmodule
